uart_fifo_top: RTL

UART_FIFO_TOP -- requirements
Module: uart_fifo_top

---
 rtl/uart_fifo_top.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_top.sv
// UART with TX/RX FIFOs, 16x oversampling, optional parity when UART_PARITY_EN is defined.
// Latency: TX start bit begins the clk after the first tick that finds data; RX word lands one clk after the stop sample.
// Backpressure: tx_ready drops when the TX FIFO is full; RX words arriving into a full FIFO are dropped and flagged as overrun.
module uart_fifo_top #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          baud_div,
  input  logic [1:0]           parity_mode,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [2:0]           rx_err,
  input  logic                 rx,
  output logic                 tx
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Parity configuration as seen at frame start; forced off when parity is not built in.
  logic par_en_cfg;
  logic par_odd_cfg;
  assign par_en_cfg  = PAR_BUILD && ((parity_mode == 2'b01) || (parity_mode == 2'b10));
  assign par_odd_cfg = PAR_BUILD && (parity_mode == 2'b10);

  // ---------------------------------------------------------------- tick
  logic [15:0] tick_cnt;
  logic        tick;
  assign tick = (tick_cnt >= baud_div);

  // Free-running oversample counter; the >= compare lets a shrinking baud_div take effect at once.
  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 16'd1;
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_push  = tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign tx_ready = !tx_full;

  // TX FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
  end

  // ---------------------------------------------------------------- TX FSM
  state_t               tx_state, tx_state_nxt;
  logic [3:0]           tx_tcnt, tx_tcnt_nxt;
  logic [2:0]           tx_bcnt, tx_bcnt_nxt;
  logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
  logic                 tx_par_en, tx_par_en_nxt;
  logic                 tx_par_bit, tx_par_bit_nxt;
  logic                 tx_nxt;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == 4'd15);
  assign tx_busy    = !tx_empty || (tx_state != IDLE);

  // TX state register; tx is registered so the line never glitches on state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= IDLE;
      tx_tcnt    <= '0;
      tx_bcnt    <= '0;
      tx_shreg   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      tx_state   <= tx_state_nxt;
      tx_tcnt    <= tx_tcnt_nxt;
      tx_bcnt    <= tx_bcnt_nxt;
      tx_shreg   <= tx_shreg_nxt;
      tx_par_en  <= tx_par_en_nxt;
      tx_par_bit <= tx_par_bit_nxt;
      tx         <= tx_nxt;
    end
  end

  // TX next state: each bit is 16 ticks; the tick counter wraps naturally at every bit boundary.
  always_comb begin
    tx_state_nxt   = tx_state;
    tx_tcnt_nxt    = tx_tcnt;
    tx_bcnt_nxt    = tx_bcnt;
    tx_shreg_nxt   = tx_shreg;
    tx_par_en_nxt  = tx_par_en;
    tx_par_bit_nxt = tx_par_bit;
    tx_pop         = 1'b0;
    if (tx_state != IDLE && tick) tx_tcnt_nxt = tx_tcnt + 4'd1;
    case (tx_state)
      IDLE: begin
        if (tick && !tx_empty) begin
          tx_pop         = 1'b1;
          tx_state_nxt   = START;
          tx_tcnt_nxt    = '0;
          tx_shreg_nxt   = tx_head;
          tx_par_en_nxt  = par_en_cfg;
          tx_par_bit_nxt = (^tx_head) ^ par_odd_cfg;
        end
      end
      START: begin
        if (tx_bit_end) begin
          tx_state_nxt = DATA;
          tx_bcnt_nxt  = '0;
        end
      end
      DATA: begin
        if (tx_bit_end) begin
          if (tx_bcnt == LAST_BIT) begin
            tx_state_nxt = tx_par_en ? PARITY : STOP;
          end else begin
            tx_bcnt_nxt  = tx_bcnt + 3'd1;
            tx_shreg_nxt = tx_shreg >> 1;
          end
        end
      end
      PARITY: if (tx_bit_end) tx_state_nxt = STOP;
      STOP:   if (tx_bit_end) tx_state_nxt = IDLE;
      default: tx_state_nxt = IDLE;
    endcase
    case (tx_state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = tx_shreg_nxt[0];
      PARITY:  tx_nxt = tx_par_bit_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX sync
  logic rx_meta, rx_sync, rx_prev, rx_fall;
  assign rx_fall = rx_prev && !rx_sync;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  state_t               rx_state, rx_state_nxt;
  logic [3:0]           rx_tcnt, rx_tcnt_nxt;
  logic [2:0]           rx_bcnt, rx_bcnt_nxt;
  logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt;
  logic                 rx_par_en, rx_par_en_nxt;
  logic                 rx_par_odd, rx_par_odd_nxt;
  logic                 rx_perr, rx_perr_nxt;
  logic                 rx_ferr, rx_ferr_nxt;
  logic                 rx_wr, rx_wr_nxt;
  logic                 rx_bit_end;

  assign rx_bit_end = tick && (rx_tcnt == 4'd15);

  // RX state register; rx_wr is the delayed write strobe issued after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= IDLE;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_shreg   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_wr      <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_tcnt    <= rx_tcnt_nxt;
      rx_bcnt    <= rx_bcnt_nxt;
      rx_shreg   <= rx_shreg_nxt;
      rx_par_en  <= rx_par_en_nxt;
      rx_par_odd <= rx_par_odd_nxt;
      rx_perr    <= rx_perr_nxt;
      rx_ferr    <= rx_ferr_nxt;
      rx_wr      <= rx_wr_nxt;
    end
  end

  // RX next state: confirm start at 8 ticks, then sample mid-bit every 16 ticks.
  always_comb begin
    rx_state_nxt   = rx_state;
    rx_tcnt_nxt    = rx_tcnt;
    rx_bcnt_nxt    = rx_bcnt;
    rx_shreg_nxt   = rx_shreg;
    rx_par_en_nxt  = rx_par_en;
    rx_par_odd_nxt = rx_par_odd;
    rx_perr_nxt    = rx_perr;
    rx_ferr_nxt    = rx_ferr;
    rx_wr_nxt      = 1'b0;
    if (rx_state != IDLE && tick) rx_tcnt_nxt = rx_tcnt + 4'd1;
    case (rx_state)
      IDLE: begin
        if (rx_fall) begin
          rx_state_nxt   = START;
          rx_tcnt_nxt    = '0;
          rx_par_en_nxt  = par_en_cfg;
          rx_par_odd_nxt = par_odd_cfg;
          rx_perr_nxt    = 1'b0;
          rx_ferr_nxt    = 1'b0;
        end
      end
      START: begin
        if (tick && rx_tcnt == 4'd7) begin
          rx_tcnt_nxt  = '0;
          rx_bcnt_nxt  = '0;
          rx_state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_bit_end) begin
          rx_shreg_nxt = {rx_sync, rx_shreg[DATA_BITS-1:1]};
          if (rx_bcnt == LAST_BIT) rx_state_nxt = rx_par_en ? PARITY : STOP;
          else                     rx_bcnt_nxt  = rx_bcnt + 3'd1;
        end
      end
      PARITY: begin
        if (rx_bit_end) begin
          rx_perr_nxt  = (rx_sync != ((^rx_shreg) ^ rx_par_odd));
          rx_state_nxt = STOP;
        end
      end
      STOP: begin
        if (rx_bit_end) begin
          rx_ferr_nxt  = !rx_sync;
          rx_wr_nxt    = 1'b1;
          rx_state_nxt = IDLE;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS+1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp;
  logic                 rx_empty, rx_full, rx_pop, rx_push, rx_drop, rx_ovr;
  logic [DATA_BITS+1:0] rx_head;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_push  = rx_wr && (!rx_full || rx_pop);
  assign rx_drop  = rx_wr && rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  // Head is masked to zero when empty so the outputs are defined out of reset.
  assign rx_data = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
  assign rx_err  = {rx_ovr, rx_valid & PAR_BUILD & rx_head[DATA_BITS+1], rx_valid & rx_head[DATA_BITS]};

  // RX FIFO pointers and sticky overrun, cleared by the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_ovr <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_pop)       rx_ovr <= 1'b0;
      else if (rx_drop) rx_ovr <= 1'b1;
    end
  end

  // RX FIFO storage: {parity error, framing error, data}.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= {rx_perr, rx_ferr, rx_shreg};
  end

endmodule
